modbus_uart_rx: RTL and testbench
=================================

MODBUS_UART_RX -- requirements
Module: modbus_uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (minimum 8).
REQ-002 Parameter SILENCE_BITS, default 39, idle bit times that define Modbus RTU inter-frame silence (t3.5 at 11 bits per char).
REQ-003 clk  input  1  clock; rising edge only; driven by the Modbus bridge's uartClk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rxd  input  1  asynchronous serial line, idle high.
REQ-006 dataOut  output  9  [7:0] received byte; [8] received parity bit.
REQ-007 dataReceived  output  1  holding register contains an unconsumed byte.
REQ-008 parityError  output  1  held byte failed even-parity check.
REQ-009 overflow  output  1  sticky; at least one byte was lost since the last acknowledge.
REQ-010 silence  output  1  line has been idle for at least SILENCE_BITS bit times.
REQ-011 receiveReq  input  1  single-cycle acknowledge from the consumer; releases the holding register.

Function
REQ-012 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized signal (rxs).
REQ-013 Frame format SHALL be: start(0), 8 data bits LSB first, even parity, 1 stop(1); 11 bits total.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; a bit counter (0..7) and a baud counter (0..CLKS_PER_BIT-1) are provided.
REQ-015 IDLE->START on rxs high-to-low transition; the baud counter is cleared.
REQ-016 START: at CLKS_PER_BIT/2 cycles, rxs==0 -> DATA with baud counter cleared; rxs==1 -> IDLE (false start, no flags change).
REQ-017 DATA: sample rxs every CLKS_PER_BIT cycles into the shift register LSB first; after 8 samples -> PARITY.
REQ-018 PARITY: sample one bit after CLKS_PER_BIT cycles -> STOP.
REQ-019 STOP: sample after CLKS_PER_BIT cycles; stop==1 -> deliver byte and go to IDLE; stop==0 (framing error) -> discard byte and go to IDLE, no flags change.
REQ-020 Delivery SHALL occur on the cycle after the stop-bit sample: dataOut<=byte/parity; parityError<=(XOR of 8 data bits and parity bit)!=0; dataReceived<=1.
REQ-021 receiveReq with dataReceived==1 SHALL clear dataReceived, parityError and overflow on the next edge; dataOut holds its value.
REQ-022 receiveReq with dataReceived==0 SHALL be ignored.
REQ-023 Delivery while dataReceived==1 without same-cycle receiveReq: the new byte is dropped, the holding register is unchanged, and overflow<=1.
REQ-024 Delivery in the same cycle as receiveReq: the new byte is loaded, dataReceived stays 1, overflow<=0.
REQ-025 Silence counter SHALL count clk cycles while FSM is IDLE and rxs==1, saturating at SILENCE_BITS*CLKS_PER_BIT; silence==1 while saturated.
REQ-026 Silence counter SHALL clear, and silence SHALL deassert, on the same edge that IDLE->START is taken; a false start restarts counting from 0.
REQ-027 Silence counter SHALL NOT advance while rxs==0 in IDLE (break condition).

Reset
REQ-028 On rst: FSM=IDLE, all counters 0, dataOut=0, dataReceived=0, parityError=0, overflow=0, silence=0, synchronizer flops=1.
REQ-029 rst mid-frame SHALL abandon the frame; the next byte is received only after a new high-to-low edge.
REQ-030 After rst release, silence SHALL assert after SILENCE_BITS*CLKS_PER_BIT cycles of idle-high rxs.

Configuration
REQ-031 Macro MODBUS_UART_RX_GLITCH_FILTER_EN defined: a 3-sample majority filter (3 additional flops) SHALL follow the synchronizer, and rxs is the filter output; input-to-decision latency becomes 4 cycles; isolated 1-cycle pulses are rejected.
REQ-032 Macro undefined: no filter; latency 2 cycles; all other behaviour identical.

Verification (CLKS_PER_BIT=16, SILENCE_BITS=39)
REQ-033 Send 0x25 with parity 1 -> dataOut=0x125, dataReceived=1, parityError=0, 1 cycle after the stop-bit mid-sample.
REQ-034 Send 0x03 with parity 1 -> dataOut=0x103, parityError=1; pulse receiveReq -> dataReceived=0, parityError=0 next cycle.
REQ-035 Send 0x11, then 0x22 without receiveReq -> dataOut[7:0]=0x11, overflow=1; receiveReq -> overflow=0.
REQ-036 rxd low for 5 cycles, then high -> no byte, silence counter restarts; idle 624 cycles -> silence=1; start edge -> silence=0 on the next edge.
REQ-037 Frame with stop bit 0 -> dataReceived stays 0; assert rst at bit 4 of a frame -> all outputs 0, the next clean frame is received correctly.
REQ-038 MODBUS_UART_RX_GLITCH_FILTER_EN defined: 1-cycle low pulse on idle rxd -> no START entry; silence is unaffected.

Source files
------------

// File: rtl/modbus_uart_rx.sv
// Modbus RTU UART receiver: 8E1 framing, single holding register, t3.5 silence detect.
// Define MODBUS_UART_RX_GLITCH_FILTER_EN to add a 3-sample majority filter after the synchronizer.
module modbus_uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int SILENCE_BITS = 39
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic       receiveReq,
    output logic [8:0] dataOut,
    output logic       dataReceived,
    output logic       parityError,
    output logic       overflow,
    output logic       silence
);

    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int SIL_MAX = SILENCE_BITS * CLKS_PER_BIT;
    localparam int SIL_W   = $clog2(SIL_MAX + 1);

    localparam logic [BAUD_W-1:0] HALF_END = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BIT_END  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [SIL_W-1:0]  SIL_TOP  = SIL_W'(SIL_MAX);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic              sync_p0;
    logic              sync_p1;
    logic              rxs;
    logic              rxs_prev;
    logic              fall;
    state_t            state;
    state_t            state_nxt;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_nxt;
    logic [2:0]        bit_cnt;
    logic [2:0]        bit_nxt;
    logic              shift_en;
    logic              par_en;
    logic              deliver_nxt;
    logic              deliver;
    logic [7:0]        shift_reg;
    logic              par_bit;
    logic [SIL_W-1:0]  sil_cnt;

    // Input synchronizer; reset to the idle level so reset never fakes a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= rxd;
            sync_p1 <= sync_p0;
        end
    end

`ifdef MODBUS_UART_RX_GLITCH_FILTER_EN
    logic [2:0] filt_p2;

    // Majority of three consecutive samples rejects single-cycle glitches
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_p2 <= 3'b111;
        end else begin
            filt_p2 <= {filt_p2[1:0], sync_p1};
        end
    end

    assign rxs = (filt_p2[0] & filt_p2[1]) | (filt_p2[0] & filt_p2[2]) | (filt_p2[1] & filt_p2[2]);
`else
    assign rxs = sync_p1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rxs_prev <= 1'b1;
        end else begin
            rxs_prev <= rxs;
        end
    end

    assign fall = rxs_prev & ~rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            deliver  <= 1'b0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            deliver  <= deliver_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        baud_nxt    = baud_cnt + 1'b1;
        bit_nxt     = bit_cnt;
        shift_en    = 1'b0;
        par_en      = 1'b0;
        deliver_nxt = 1'b0;
        case (state)
            IDLE: begin
                baud_nxt = '0;
                bit_nxt  = '0;
                if (fall) state_nxt = START;
            end
            START: begin
                // Mid-start-bit recheck; a line back high is a false start
                if (baud_cnt == HALF_END) begin
                    baud_nxt  = '0;
                    state_nxt = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_END) begin
                    baud_nxt = '0;
                    shift_en = 1'b1;
                    bit_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                end
            end
            PARITY: begin
                if (baud_cnt == BIT_END) begin
                    baud_nxt  = '0;
                    par_en    = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_cnt == BIT_END) begin
                    baud_nxt    = '0;
                    deliver_nxt = rxs;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
        if (par_en)   par_bit   <= rxs;
    end

    // Holding register: a delivery into an occupied, unacknowledged register is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            dataOut      <= '0;
            dataReceived <= 1'b0;
            parityError  <= 1'b0;
            overflow     <= 1'b0;
        end else if (deliver && (!dataReceived || receiveReq)) begin
            dataOut      <= {par_bit, shift_reg};
            parityError  <= ^{par_bit, shift_reg};
            dataReceived <= 1'b1;
            overflow     <= 1'b0;
        end else if (deliver) begin
            overflow     <= 1'b1;
        end else if (receiveReq && dataReceived) begin
            dataReceived <= 1'b0;
            parityError  <= 1'b0;
            overflow     <= 1'b0;
        end
    end

    // Silence counter holds during a break (rxs low in IDLE) and is zero throughout a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            sil_cnt <= '0;
        end else if (state != IDLE || fall) begin
            sil_cnt <= '0;
        end else if (rxs && sil_cnt != SIL_TOP) begin
            sil_cnt <= sil_cnt + 1'b1;
        end
    end

    assign silence = (sil_cnt == SIL_TOP);

endmodule

// File: tb/tb_modbus_uart_rx.sv
// Directed bench for modbus_uart_rx at CLKS_PER_BIT=16, SILENCE_BITS=39.
module tb_modbus_uart_rx;

    localparam int CPB = 16;
    localparam int SB  = 39;
`ifdef MODBUS_UART_RX_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       receiveReq = 1'b0;
    logic [8:0] dataOut;
    logic       dataReceived;
    logic       parityError;
    logic       overflow;
    logic       silence;

    int total  = 0;
    int passed = 0;

    modbus_uart_rx #(.CLKS_PER_BIT(CPB), .SILENCE_BITS(SB)) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .receiveReq(receiveReq),
        .dataOut(dataOut),
        .dataReceived(dataReceived),
        .parityError(parityError),
        .overflow(overflow),
        .silence(silence)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        drive_bit(s);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic ack();
        receiveReq = 1'b1;
        @(negedge clk);
        receiveReq = 1'b0;
        @(negedge clk);
    endtask

    logic [7:0] first_byte;
    logic [7:0] rst_byte;

    initial begin
        first_byte = 8'h25;
        rst_byte   = 8'hF1;

        repeat (3) @(negedge clk);
        check("rst_dataOut", 16'(dataOut), 16'h000);
        check("rst_dataReceived", 16'(dataReceived), 16'h0);
        check("rst_parityError", 16'(parityError), 16'h0);
        check("rst_overflow", 16'(overflow), 16'h0);
        check("rst_silence", 16'(silence), 16'h0);

        // Silence asserts exactly SB*CPB edges after reset release
        rst = 1'b0;
        repeat (SB * CPB - 1) @(posedge clk);
        #1 check("silence_pre_sat", 16'(silence), 16'h0);
        @(posedge clk);
        #1 check("silence_sat", 16'(silence), 16'h1);

        // Frame 0x25 parity 1, cycle-accurate start and delivery checks
        @(negedge clk);
        rxd = 1'b0;
        repeat (LAT) @(posedge clk);
        #1 check("silence_before_start_edge", 16'(silence), 16'h1);
        @(posedge clk);
        #1 check("silence_cleared_on_start", 16'(silence), 16'h0);
        repeat (16 - LAT) @(negedge clk);
        for (int i = 0; i < 8; i++) drive_bit(first_byte[i]);
        drive_bit(1'b1);
        rxd = 1'b1;
        repeat (9 + LAT) @(posedge clk);
        #1 check("dr_at_stop_sample", 16'(dataReceived), 16'h0);
        @(posedge clk);
        #1 check("dr_after_stop_sample", 16'(dataReceived), 16'h1);
        check("data_0x25", 16'(dataOut), 16'h125);
        check("perr_0x25", 16'(parityError), 16'h0);
        check("ovf_0x25", 16'(overflow), 16'h0);
        repeat (7 - LAT) @(negedge clk);
        repeat (4) @(negedge clk);
        ack();
        check("ack_dr_0x25", 16'(dataReceived), 16'h0);
        check("ack_hold_0x25", 16'(dataOut), 16'h125);

        // Parity error byte
        send_frame(8'h03, 1'b1, 1'b1);
        check("data_0x03", 16'(dataOut), 16'h103);
        check("perr_0x03", 16'(parityError), 16'h1);
        check("dr_0x03", 16'(dataReceived), 16'h1);
        ack();
        check("ack_dr_0x03", 16'(dataReceived), 16'h0);
        check("ack_perr_0x03", 16'(parityError), 16'h0);
        check("ack_hold_0x03", 16'(dataOut), 16'h103);

        // Overflow: second byte dropped while the first is unacknowledged
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        check("ovf_data", 16'(dataOut[7:0]), 16'h11);
        check("ovf_flag", 16'(overflow), 16'h1);
        check("ovf_dr", 16'(dataReceived), 16'h1);
        ack();
        check("ack_ovf", 16'(overflow), 16'h0);
        check("ack_ovf_dr", 16'(dataReceived), 16'h0);

        // False start then silence regained
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (600) @(negedge clk);
        check("false_start_silence_early", 16'(silence), 16'h0);
        check("false_start_no_byte", 16'(dataReceived), 16'h0);
        repeat (60) @(negedge clk);
        check("false_start_silence_late", 16'(silence), 16'h1);

        // Framing error: byte discarded
        send_frame(8'h55, 1'b0, 1'b0);
        check("frame_err_dr", 16'(dataReceived), 16'h0);
        check("frame_err_ovf", 16'(overflow), 16'h0);

        // Reset during data bit 4 of 0xF1; remaining bits are all high
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(rst_byte[i]);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_dataOut", 16'(dataOut), 16'h000);
        check("midrst_dr", 16'(dataReceived), 16'h0);
        check("midrst_perr", 16'(parityError), 16'h0);
        check("midrst_ovf", 16'(overflow), 16'h0);
        check("midrst_silence", 16'(silence), 16'h0);
        repeat (9 + 5 * CPB) @(negedge clk);
        check("midrst_no_byte", 16'(dataReceived), 16'h0);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("post_rst_data", 16'(dataOut), 16'h05A);
        check("post_rst_perr", 16'(parityError), 16'h0);
        check("post_rst_dr", 16'(dataReceived), 16'h1);

`ifdef MODBUS_UART_RX_GLITCH_FILTER_EN
        ack();
        repeat (SB * CPB + 20) @(negedge clk);
        check("glitch_silence_pre", 16'(silence), 16'h1);
        rxd = 1'b0;
        @(negedge clk);
        rxd = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch_silence_kept", 16'(silence), 16'h1);
        check("glitch_no_byte", 16'(dataReceived), 16'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
